// File: rtl/regfile_write_arbiter_if.sv
// Handshake and data signals between the pipeline, the long-latency unit and the register-file write arbiter.
// No logic, no latency: the interface only carries wires.
// Backpressure is carried by wb_hold_o (writeback) and lu_ready_o (long-latency results).
interface regfile_write_arbiter_if;
   logic        wb_req;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_hold_o;
   logic        lu_valid;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        lu_ready_o;
   logic        lu_issue;
   logic [4:0]  lu_issue_addr;
   logic [4:0]  a_addr;
   logic [4:0]  b_addr;
   logic        hazard_o;
   logic [31:0] busy_o;
   logic        write_sig;
   logic [4:0]  d_addr;
   logic [31:0] writeback_data;
   logic        a_fwd_valid_o;
   logic [31:0] a_fwd_data_o;

   // Driver side: pipeline, long-latency unit and decode.
   modport master (
      output wb_req, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
      output lu_issue, lu_issue_addr, a_addr, b_addr,
      input  wb_hold_o, lu_ready_o, hazard_o, busy_o,
      input  write_sig, d_addr, writeback_data, a_fwd_valid_o, a_fwd_data_o
   );

   // Arbiter side.
   modport slave (
      input  wb_req, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
      input  lu_issue, lu_issue_addr, a_addr, b_addr,
      output wb_hold_o, lu_ready_o, hazard_o, busy_o,
      output write_sig, d_addr, writeback_data, a_fwd_valid_o, a_fwd_data_o
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and a FIFO of long-latency results; keeps a busy scoreboard.
// Latency: a grant is registered onto the write port one cycle later; a pushed result is written two cycles after the push at the earliest.
// Backpressure: lu_ready_o drops when the FIFO is full; wb_hold_o freezes writeback while a starved FIFO is forced to win. Optional macro: REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic                    clock,
   input logic                    Rest,
   regfile_write_arbiter_if.slave bus
);
   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [7:0]  LIMIT   = 8'(STARVE_LIMIT);

   logic [4:0]    fifo_addr [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    starve_cnt;
   logic          rst_done;
   logic [31:0]   busy;
   logic          from_fifo;
   logic          write_sig;
   logic [4:0]    d_addr;
   logic [31:0]   wr_data;

   logic          fifo_ne;
   logic          full;
   logic          lu_ready;
   logic          push;
   logic          force_fifo;
   logic          grant_fifo;
   logic          grant_wb;
   logic [4:0]    win_addr;
   logic [31:0]   win_data;
   logic [31:0]   clr_mask;
   logic [31:0]   set_mask;

   assign fifo_ne  = (count != '0);
   assign full     = (count == DEPTH_L);
   // Ready stays low until the first edge after reset release.
   assign lu_ready = rst_done & ~full;
   assign push     = bus.lu_valid & lu_ready;

   // A FIFO that has lost STARVE_LIMIT times in a row takes the port and freezes writeback.
   assign force_fifo = fifo_ne & (starve_cnt == LIMIT);
   assign grant_fifo = fifo_ne & (force_fifo | ~bus.wb_req);
   assign grant_wb   = bus.wb_req & ~force_fifo;
   assign win_addr   = grant_fifo ? fifo_addr[rd_ptr] : bus.wb_addr;
   assign win_data   = grant_fifo ? fifo_data[rd_ptr] : bus.wb_data;

   // Only long-latency writes retire busy bits; a new issue to the same register wins.
   assign clr_mask = (write_sig & from_fifo) ? (32'd1 << d_addr) : 32'd0;
   assign set_mask = (bus.lu_issue && bus.lu_issue_addr != 5'd0) ? (32'd1 << bus.lu_issue_addr) : 32'd0;

   // FIFO storage: payload needs no reset, the pointers decide what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.lu_addr;
         fifo_data[wr_ptr] <= bus.lu_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock or negedge Rest) begin
      if (!Rest) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (grant_fifo)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !grant_fifo)
            count <= count + 1'b1;
         else if (!push && grant_fifo)
            count <= count - 1'b1;
      end
   end

   // Starvation counter: counts writeback wins over a waiting FIFO, saturating at the limit.
   always_ff @(posedge clock or negedge Rest) begin
      if (!Rest)
         starve_cnt <= 8'd0;
      else if (!fifo_ne || grant_fifo)
         starve_cnt <= 8'd0;
      else if (grant_wb && starve_cnt < LIMIT)
         starve_cnt <= starve_cnt + 8'd1;
   end

   // Registered write port; address 0 still consumes the grant but never asserts the enable.
   always_ff @(posedge clock or negedge Rest) begin
      if (!Rest) begin
         write_sig <= 1'b0;
         d_addr    <= 5'd0;
         wr_data   <= 32'd0;
         from_fifo <= 1'b0;
      end else if (grant_fifo || grant_wb) begin
         write_sig <= (win_addr != 5'd0);
         d_addr    <= win_addr;
         wr_data   <= win_data;
         from_fifo <= grant_fifo;
      end else begin
         write_sig <= 1'b0;
         from_fifo <= 1'b0;
      end
   end

   // Busy scoreboard of registers with outstanding long-latency writes.
   always_ff @(posedge clock or negedge Rest) begin
      if (!Rest)
         busy <= 32'd0;
      else
         busy <= (busy & ~clr_mask) | set_mask;
   end

   assign bus.lu_ready_o     = lu_ready;
   assign bus.wb_hold_o      = force_fifo;
   assign bus.busy_o         = busy;
   assign bus.hazard_o       = busy[bus.a_addr] | busy[bus.b_addr];
   assign bus.write_sig      = write_sig;
   assign bus.d_addr         = d_addr;
   assign bus.writeback_data = wr_data;

`ifdef REGFILE_ARB_BYPASS_EN
   assign bus.a_fwd_valid_o  = write_sig & (d_addr == bus.a_addr) & (bus.a_addr != 5'd0);
   assign bus.a_fwd_data_o   = wr_data;
`else
   assign bus.a_fwd_valid_o  = 1'b0;
   assign bus.a_fwd_data_o   = 32'd0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors, a queue-based reference model and per-cycle output comparison.
// Latency under test: grant registered one cycle later; scoreboard clear one cycle after the FIFO write.
// Backpressure under test: FIFO full, forced starvation grant with writeback hold, reset mid-operation.
module tb_regfile_write_arbiter;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic clock = 1'b0;
   logic Rest  = 1'b0;
   int   errors = 0;
   int   checks = 0;

   regfile_write_arbiter_if bus();

   regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clock (clock),
      .Rest  (Rest),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending results as a queue, write port as last granted transaction.
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   ent_t        e;
   int          starve   = 0;
   bit          m_we     = 0;
   logic [4:0]  m_addr   = 0;
   logic [31:0] m_data   = 0;
   bit          m_fromf  = 0;
   logic [31:0] m_busy   = 0;
   bit          rdy_seen = 0;
   bit          cmp_en   = 0;
   int          n;
   bit          forced, fifo_win, wb_win, do_push;
   logic [31:0] nb;

   always @(posedge clock or negedge Rest) begin
      if (!Rest) begin
         q.delete();
         starve = 0; m_we = 0; m_addr = 0; m_data = 0; m_fromf = 0; m_busy = 0; rdy_seen = 0;
      end else begin
         n        = q.size();
         forced   = (n > 0) && (starve == LIMIT);
         fifo_win = (n > 0) && (forced || !bus.wb_req);
         wb_win   = bus.wb_req && !forced;
         do_push  = bus.lu_valid && rdy_seen && (n < DEPTH);
         nb = m_busy;
         if (m_we && m_fromf) nb[m_addr] = 1'b0;
         if (bus.lu_issue && bus.lu_issue_addr != 0) nb[bus.lu_issue_addr] = 1'b1;
         m_busy = nb;
         if (n == 0 || fifo_win) starve = 0;
         else if (wb_win && starve < LIMIT) starve++;
         if (fifo_win) begin
            e = q.pop_front();
            m_we = (e.a != 0); m_addr = e.a; m_data = e.d; m_fromf = 1;
         end else if (wb_win) begin
            m_we = (bus.wb_addr != 0); m_addr = bus.wb_addr; m_data = bus.wb_data; m_fromf = 0;
         end else begin
            m_we = 0; m_fromf = 0;
         end
         if (do_push) q.push_back('{bus.lu_addr, bus.lu_data});
         rdy_seen = 1;
      end
   end

   // Per-cycle comparison, sampled on the falling edge.
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("write_sig", {31'd0, bus.write_sig}, {31'd0, m_we});
         chk("d_addr", {27'd0, bus.d_addr}, {27'd0, m_addr});
         chk("writeback_data", bus.writeback_data, m_data);
         chk("busy_o", bus.busy_o, m_busy);
         chk("hazard_o", {31'd0, bus.hazard_o}, {31'd0, m_busy[bus.a_addr] | m_busy[bus.b_addr]});
         chk("wb_hold_o", {31'd0, bus.wb_hold_o}, {31'd0, (q.size() > 0) && (starve == LIMIT)});
         chk("lu_ready_o", {31'd0, bus.lu_ready_o}, {31'd0, rdy_seen && (q.size() < DEPTH)});
`ifdef REGFILE_ARB_BYPASS_EN
         chk("a_fwd_valid_o", {31'd0, bus.a_fwd_valid_o}, {31'd0, m_we && (m_addr == bus.a_addr) && (bus.a_addr != 0)});
         chk("a_fwd_data_o", bus.a_fwd_data_o, m_data);
`else
         chk("a_fwd_valid_o", {31'd0, bus.a_fwd_valid_o}, 32'd0);
         chk("a_fwd_data_o", bus.a_fwd_data_o, 32'd0);
`endif
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   int cnt;

   initial begin
      bus.wb_req = 0; bus.wb_addr = 0; bus.wb_data = 0;
      bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
      bus.lu_issue = 0; bus.lu_issue_addr = 0;
      bus.a_addr = 0; bus.b_addr = 0;
      cyc(); cyc();
      cmp_en = 1;
      chk("rst_ready", {31'd0, bus.lu_ready_o}, 32'd0);
      chk("rst_write_sig", {31'd0, bus.write_sig}, 32'd0);
      Rest = 1;
      cyc();
      chk("release_ready", {31'd0, bus.lu_ready_o}, 32'd1);

      // Writeback only
      bus.wb_req = 1; bus.wb_addr = 5; bus.wb_data = 32'hDEADBEEF;
      #1 chk("wb_hold_idle", {31'd0, bus.wb_hold_o}, 32'd0);
      cyc();
      bus.wb_req = 0;
      chk("wb_write_sig", {31'd0, bus.write_sig}, 32'd1);
      chk("wb_d_addr", {27'd0, bus.d_addr}, 32'd5);
      chk("wb_data", bus.writeback_data, 32'hDEADBEEF);

      // Long-latency result alone
      bus.lu_issue = 1; bus.lu_issue_addr = 9;
      cyc();
      bus.lu_issue = 0;
      chk("busy9_set", {31'd0, bus.busy_o[9]}, 32'd1);
      bus.a_addr = 9;
      #1 chk("hazard9", {31'd0, bus.hazard_o}, 32'd1);
      bus.lu_valid = 1; bus.lu_addr = 9; bus.lu_data = 32'h1234;
      cyc();
      bus.lu_valid = 0;
      cyc();
      chk("lu_write_sig", {31'd0, bus.write_sig}, 32'd1);
      chk("lu_d_addr", {27'd0, bus.d_addr}, 32'd9);
      chk("lu_data", bus.writeback_data, 32'h1234);
      chk("busy9_during_write", {31'd0, bus.busy_o[9]}, 32'd1);
      cyc();
      chk("busy9_cleared", {31'd0, bus.busy_o[9]}, 32'd0);
      bus.a_addr = 0;

      // Starvation: one FIFO entry against a continuous writeback stream
      bus.wb_req = 1; bus.wb_addr = 10; bus.wb_data = 32'hA0;
      bus.lu_valid = 1; bus.lu_addr = 3; bus.lu_data = 32'h33;
      cyc();
      bus.lu_valid = 0;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         bus.wb_addr = 5'(11 + k); bus.wb_data = 32'hB0 + k;
         #1;
         if (bus.wb_hold_o) break;
         cnt++;
         cyc();
      end
      chk("starve_wb_grants", cnt, 32'd8);
      cyc();
      chk("forced_d_addr", {27'd0, bus.d_addr}, 32'd3);
      chk("forced_data", bus.writeback_data, 32'h33);
      chk("hold_released", {31'd0, bus.wb_hold_o}, 32'd0);
      cyc();
      chk("held_wb_d_addr", {27'd0, bus.d_addr}, 32'(11 + cnt));
      bus.wb_req = 0;
      cyc();

      // Full FIFO under writeback pressure
      bus.wb_req = 1; bus.wb_addr = 2; bus.wb_data = 32'h22;
      for (int k = 0; k < 4; k++) begin
         bus.lu_valid = 1; bus.lu_addr = 5'(16 + k); bus.lu_data = 32'h100 + k;
         cyc();
      end
      bus.lu_addr = 20; bus.lu_data = 32'h104;
      chk("full_ready", {31'd0, bus.lu_ready_o}, 32'd0);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (bus.wb_hold_o) break;
         cnt++;
         cyc();
      end
      chk("full_wb_grants", cnt, 32'd5);
      cyc();
      chk("full_forced_addr", {27'd0, bus.d_addr}, 32'd16);
      chk("full_after_pop_ready", {31'd0, bus.lu_ready_o}, 32'd1);
      cyc();
      bus.lu_valid = 0;
      chk("refull_ready", {31'd0, bus.lu_ready_o}, 32'd0);
      bus.wb_req = 0;
      for (int k = 0; k < 4; k++) cyc();
      chk("drain_last_addr", {27'd0, bus.d_addr}, 32'd20);
      chk("drain_ready", {31'd0, bus.lu_ready_o}, 32'd1);
      cyc();

      // Register 0 from both sources
      bus.lu_issue = 1; bus.lu_issue_addr = 0;
      bus.wb_req = 1; bus.wb_addr = 0; bus.wb_data = 32'h55;
      bus.lu_valid = 1; bus.lu_addr = 0; bus.lu_data = 32'hAA;
      cyc();
      bus.lu_issue = 0; bus.wb_req = 0; bus.lu_valid = 0;
      chk("r0_wb_write_sig", {31'd0, bus.write_sig}, 32'd0);
      cyc();
      chk("r0_lu_write_sig", {31'd0, bus.write_sig}, 32'd0);
      chk("r0_lu_data", bus.writeback_data, 32'hAA);
      chk("r0_busy", bus.busy_o, 32'd0);
      cyc();

      // Reset in the middle of buffered traffic
      bus.wb_req = 1; bus.wb_addr = 1; bus.wb_data = 32'h11;
      bus.lu_issue = 1; bus.lu_issue_addr = 9;
      cyc();
      bus.lu_issue_addr = 10; bus.lu_valid = 1; bus.lu_addr = 9; bus.lu_data = 32'h90;
      cyc();
      bus.lu_issue_addr = 11; bus.lu_addr = 10; bus.lu_data = 32'hA0;
      cyc();
      bus.lu_issue = 0; bus.lu_addr = 11; bus.lu_data = 32'hB0;
      cyc();
      bus.lu_valid = 0;
      chk("pre_reset_busy", bus.busy_o, 32'h0000_0E00);
      bus.a_addr = 10;
      Rest = 0;
      #1;
      chk("mid_rst_write_sig", {31'd0, bus.write_sig}, 32'd0);
      chk("mid_rst_busy", bus.busy_o, 32'd0);
      chk("mid_rst_ready", {31'd0, bus.lu_ready_o}, 32'd0);
      chk("mid_rst_hazard", {31'd0, bus.hazard_o}, 32'd0);
      chk("mid_rst_d_addr", {27'd0, bus.d_addr}, 32'd0);
      bus.wb_req = 0;
      cyc();
      Rest = 1;
      cyc();
      chk("post_rst_ready", {31'd0, bus.lu_ready_o}, 32'd1);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.write_sig) cnt++;
         cyc();
      end
      chk("no_stale_writes", cnt, 32'd0);

      cmp_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
